// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 64x8 RAM between CPU and loader ports.
// Optional RAM_ARB_STATS_EN adds saturating grant/conflict counters.
module ram_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [3:0] MAXH = 4'(MAX_HOLD);

  state_t      state;
  logic        ptr;
  logic [3:0]  hold;
  logic [3:0]  hold_inc;
  logic        we_q;
  logic        rd_pend;
  logic        rd_port;

  assign hold_inc = hold + 4'd1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      ARB: begin
        if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
        else if (req1)               gnt1 = 1'b1;
      end
      LOCK0: begin
        if (req0)      gnt0 = 1'b1;
        else if (req1) gnt1 = 1'b1;
      end
      LOCK1: begin
        if (req1)      gnt1 = 1'b1;
        else if (req0) gnt0 = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      ptr   <= 1'b0;
      hold  <= 4'd0;
    end else begin
      unique case (state)
        ARB: begin
          if (gnt0 || gnt1) ptr <= gnt0;
          // a hold limit of 1 releases a contended lock immediately
          if (gnt0 && lock0 && !(req1 && MAXH <= 4'd1)) begin
            state <= LOCK0;
            hold  <= 4'd1;
          end else if (gnt1 && lock1 && !(req0 && MAXH <= 4'd1)) begin
            state <= LOCK1;
            hold  <= 4'd1;
          end
        end
        LOCK0: begin
          if (gnt0) begin
            if (!lock0 || (req1 && hold_inc >= MAXH)) begin
              state <= ARB;
              ptr   <= 1'b1;
              hold  <= 4'd0;
            end else if (req1) begin
              hold <= hold_inc;
            end
          end else if (gnt1) begin
            ptr   <= 1'b0;
            state <= lock1 ? LOCK1 : ARB;
            hold  <= lock1 ? 4'd1 : 4'd0;
          end else begin
            state <= ARB;
            ptr   <= 1'b1;
            hold  <= 4'd0;
          end
        end
        LOCK1: begin
          if (gnt1) begin
            if (!lock1 || (req0 && hold_inc >= MAXH)) begin
              state <= ARB;
              ptr   <= 1'b0;
              hold  <= 4'd0;
            end else if (req0) begin
              hold <= hold_inc;
            end
          end else if (gnt0) begin
            ptr   <= 1'b1;
            state <= lock0 ? LOCK0 : ARB;
            hold  <= lock0 ? 4'd1 : 4'd0;
          end else begin
            state <= ARB;
            ptr   <= 1'b0;
            hold  <= 4'd0;
          end
        end
        default: begin
          state <= ARB;
          hold  <= 4'd0;
        end
      endcase
    end
  end

  // reset must suppress a write already sitting in the command register
  assign ram_we = we_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      we_q    <= (gnt0 & we0) | (gnt1 & we1);
      rd_pend <= (gnt0 & ~we0) | (gnt1 & ~we1);
      rd_port <= gnt1;
      if (gnt0) begin
        ram_addr  <= addr0;
        ram_wdata <= wdata0;
      end else if (gnt1) begin
        ram_addr  <= addr1;
        ram_wdata <= wdata1;
      end
      rvalid0 <= rd_pend & ~rd_port;
      rvalid1 <= rd_pend & rd_port;
      if (rd_pend && !rd_port) rdata0 <= ram_rdata;
      if (rd_pend && rd_port)  rdata1 <= ram_rdata;
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0     <= 16'd0;
      stat_gnt1     <= 16'd0;
      stat_conflict <= 16'd0;
    end else begin
      if (gnt0 && stat_gnt0 != 16'hFFFF)
        stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt1 && stat_gnt1 != 16'hFFFF)
        stat_gnt1 <= stat_gnt1 + 16'd1;
      if (req0 && req1 && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x8 RAM.
// Covers RAM_ARB_STATS_EN counters when that macro is defined.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  logic [7:0] mem [64];
  logic       loaded;
  int         checks = 0;
  int         errors = 0;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[34] <= 8'h5A;
      mem[63] <= 8'hC3;
      mem[5]  <= 8'h33;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rr_port [4];
    rr_port = '{2'b01, 2'b10, 2'b01, 2'b10};
    loaded = 1'b0;
    reset = 1'b1;
    {req0, req1, we0, we1, lock0, lock1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    step();
    loaded = 1'b1;
    step();
    #1;
    chk("rst_gnt", 16'({gnt1, gnt0}), 16'h0);
    chk("rst_rvalid", 16'({rvalid1, rvalid0}), 16'h0);
    chk("rst_rdata", {rdata1, rdata0}, 16'h0);
    chk("rst_we", 16'(ram_we), 16'h0);
    chk("rst_addr", 16'(ram_addr), 16'h0);
    chk("rst_wdata", 16'(ram_wdata), 16'h0);
`ifdef RAM_ARB_STATS_EN
    chk("rst_stats", stat_gnt0 | stat_gnt1 | stat_conflict, 16'h0);
`endif
    reset = 1'b0;
    step();
    #1;
    chk("idle_gnt", 16'({gnt1, gnt0}), 16'h0);

    // round robin, both ports reading
    addr0 = 6'd34;
    addr1 = 6'd63;
    for (int i = 0; i < 6; i++) begin
      step();
      req0 = (i < 4);
      req1 = (i < 4);
      #1;
      chk($sformatf("rr_gnt%0d", i), 16'({gnt1, gnt0}),
          (i < 4) ? 16'(rr_port[i]) : 16'h0);
      if (i >= 2) begin
        chk($sformatf("rr_rvalid%0d", i), 16'({rvalid1, rvalid0}),
            16'(rr_port[i-2]));
        if (rr_port[i-2] == 2'b01)
          chk($sformatf("rr_rdata%0d", i), 16'(rdata0), 16'h5A);
        else
          chk($sformatf("rr_rdata%0d", i), 16'(rdata1), 16'hC3);
      end
    end

    // write then read-after-write on port 0
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 8'd10;
    #1;
    chk("wr_gnt", 16'({gnt1, gnt0}), 16'h1);
    step();
    we0 = 1'b0;
    #1;
    chk("rd_gnt", 16'({gnt1, gnt0}), 16'h1);
    chk("wr_ram_we", 16'(ram_we), 16'h1);
    chk("wr_ram_addr", 16'(ram_addr), 16'h3);
    chk("wr_ram_wdata", 16'(ram_wdata), 16'd10);
    step();
    req0 = 1'b0;
    #1;
    chk("rd_ram_we", 16'(ram_we), 16'h0);
    chk("rd_ram_addr", 16'(ram_addr), 16'h3);
    chk("rd_rvalid_early", 16'({rvalid1, rvalid0}), 16'h0);
    step();
    #1;
    chk("rd_rvalid", 16'({rvalid1, rvalid0}), 16'h1);
    chk("rd_rdata", 16'(rdata0), 16'd10);
    step();
    #1;
    chk("rd_rvalid_once", 16'({rvalid1, rvalid0}), 16'h0);

    // port 1 locked against a requesting port 0
    addr0 = 6'd34;
    addr1 = 6'd63;
    for (int i = 0; i < 6; i++) begin
      step();
      req0 = (i < 5);
      req1 = (i < 5);
      lock1 = (i < 5);
      #1;
      chk($sformatf("lock_gnt%0d", i), 16'({gnt1, gnt0}),
          (i < 4) ? 16'h2 : (i == 4) ? 16'h1 : 16'h0);
    end
`ifdef RAM_ARB_STATS_EN
    chk("stat_conflict", stat_conflict, 16'd9);
    chk("stat_gnt0", stat_gnt0, 16'd5);
    chk("stat_gnt1", stat_gnt1, 16'd6);
`endif

    // reset lands on the cycle after a granted write
    step();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd5; wdata1 = 8'hAA;
    #1;
    chk("rst_wr_gnt", 16'({gnt1, gnt0}), 16'h2);
    step();
    reset = 1'b1;
    req1 = 1'b0;
    #1;
    chk("rst_wr_we", 16'(ram_we), 16'h0);
    chk("rst_wr_gnt_off", 16'({gnt1, gnt0}), 16'h0);
    step();
    #1;
    chk("rst_mid_addr", 16'(ram_addr), 16'h0);
    chk("rst_mid_rvalid", 16'({rvalid1, rvalid0}), 16'h0);
`ifdef RAM_ARB_STATS_EN
    chk("rst_mid_stats", stat_gnt0 | stat_gnt1 | stat_conflict, 16'h0);
`endif
    reset = 1'b0;
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd5;
    #1;
    chk("post_rd_gnt", 16'({gnt1, gnt0}), 16'h2);
    step();
    req1 = 1'b0;
    #1;
    chk("post_rvalid_early", 16'({rvalid1, rvalid0}), 16'h0);
    step();
    #1;
    chk("post_rvalid", 16'({rvalid1, rvalid0}), 16'h2);
    chk("post_rdata", 16'(rdata1), 16'h33);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 64x8 data RAM between two requesters: port 0 (CPU datapath) and port 1 (loader/debug master).
- Arbitration is round-robin. A requester can lock ownership for back-to-back accesses, and a hold limit bounds starvation.
- The arbiter registers the winning command and drives the RAM's write_enable/address/input_data. It returns read data through a per-port valid strobe.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_HOLD, 4, maximum consecutive grants to a locked owner while the other port is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request, per port.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- lock0, lock1  in  1  request to retain ownership after this grant.
- gnt0, gnt1  out  1  combinational; request accepted at the end of this cycle.
- rvalid0, rvalid1  out  1  registered; rdataN is valid this cycle.
- rdata0, rdata1  out  DATA_W  registered read data.
- ram_we  out  1  RAM write_enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM input_data.
- ram_rdata  in  DATA_W  RAM output_data; asynchronous read of ram_addr.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- RAM model: writes at the rising edge when ram_we=1; reads are combinational from ram_addr.
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0.
  - ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - State = ARB, priority pointer = port 0, hold counter = 0.
- Reset mid-operation: the in-flight command is dropped. No write occurs on the edge where reset=1, and no rvalid follows.
- Pipeline:
  - Cycle N: arbitration; gnt asserted.
  - Cycle N+1: the command register drives ram_*. A write commits at the end of N+1. For a read, ram_rdata is captured into rdataN at the end of N+1.
  - Cycle N+2: rvalidN=1 for exactly one cycle.
  - Throughput: one access per cycle. Writes produce no rvalid.
- When no port is granted in cycle N: ram_we=0 in N+1; ram_addr/ram_wdata hold their last values.
- At most one of gnt0/gnt1 is high in any cycle. gntN is never high without reqN.
- States:
  - ARB: only one port requesting -> grant it. Both requesting -> grant the pointer port. After any grant, the pointer moves to the other port. If the granted port had lockN=1 -> LOCKN with hold=1.
  - LOCKN:
    - Grant portN whenever reqN=1, even if the other port requests; hold increments only when the other port is requesting.
    - lockN=0 at a grant, or reqN=0 -> ARB; the pointer points away from N.
    - hold reaches MAX_HOLD with the other port requesting -> forced to ARB and the other port is granted next cycle.
    - The other port requesting while reqN=0 -> grant the other port that same cycle and go to ARB, or to its lock state if its lock=1.
- Read-after-write to the same address in consecutive cycles returns the new data; commands are applied in grant order.
- Address wraps naturally at 2^ADDR_W; no range checking.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16 bits each): total grants per port.
  - Adds output stat_conflict (16 bits): cycles with req0 & req1 both high.
  - All counters saturate at 16'hFFFF and clear on reset.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all outputs 0, ram_we=0; no gnt with req0=req1=0.
- Single write then read: port0 writes 8'd10 to addr 3, then reads addr 3 -> gnt0 in each request cycle; ram_we=1 with ram_addr=3 one cycle after the first; rvalid0=1, rdata0=8'd10 two cycles after the read grant.
- Round-robin: req0=req1=1 continuously with reads of addr 34 (port0) and 63 (port1) -> grants alternate 0,1,0,1; rvalid alternates with the correct data.
- Lock with hold limit (MAX_HOLD=4): port1 locked, port0 requesting -> exactly 4 consecutive gnt1, then gnt0; stat_conflict increments each contended cycle when RAM_ARB_STATS_EN is defined.
- Reset mid-access: port1 write of 8'hAA to addr 5 granted, reset asserted in the next cycle -> addr 5 unchanged on a later read; no rvalid1 after reset.
